int_issue_queue: RTL and testbench



---
 rtl/int_issue_queue_pkg.sv | 53 +++++
 rtl/int_issue_queue_iq_wakeup.sv | 35 +++
 rtl/int_issue_queue.sv | 187 ++++++++++++++++++
 tb/tb_int_issue_queue.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_issue_queue_pkg.sv
// -----------------------------------------------------------------------------
// int_issue_queue_pkg
// Shared types for the integer issue queue:
//   opcode_e          - integer/branch opcode encoding
//   int_fifo_data     - payload handed to the integer execution unit
//   cdb_bfm           - common data bus broadcast used for operand wakeup
//   int_dispatch_data - payload plus source-operand tags and ready flags
// -----------------------------------------------------------------------------
package int_issue_queue_pkg;

    localparam int IQ_TAG_W = 6;
    localparam int XLEN     = 32;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SLT = 4'd5,
        OP_BEQ = 4'd6,
        OP_BNE = 4'd7
    } opcode_e;

    typedef struct packed {
        opcode_e             opcode;
        logic [IQ_TAG_W-1:0] rd_tag;
        logic [XLEN-1:0]     rs1_data;
        logic [XLEN-1:0]     rs2_data;
        logic                wb_valid;
    } int_fifo_data;

    typedef struct packed {
        logic                cdb_valid;
        logic [IQ_TAG_W-1:0] cdb_tag;
        logic [XLEN-1:0]     cdb_result;
        logic                cdb_branch;
    } cdb_bfm;

    typedef struct packed {
        int_fifo_data        payload;
        logic [IQ_TAG_W-1:0] rs1_tag;
        logic                rs1_ready;
        logic [IQ_TAG_W-1:0] rs2_tag;
        logic                rs2_ready;
    } int_dispatch_data;

    // An op may issue once both of its source operands hold real values.
    function automatic logic both_ready(input int_dispatch_data e);
        return e.rs1_ready & e.rs2_ready;
    endfunction

endpackage : int_issue_queue_pkg

// File: rtl/int_issue_queue_iq_wakeup.sv
// -----------------------------------------------------------------------------
// int_issue_queue_iq_wakeup
// One source operand's wakeup: compares the operand tag against the CDB and,
// on a hit, substitutes the broadcast result and marks the operand ready.
// Ports:
//   cdb_i   - CDB broadcast
//   ready_i - operand already holds its value
//   tag_i   - producer tag the operand waits on
//   data_i  - current operand value
//   ready_o - ready flag after this cycle's broadcast
//   data_o  - operand value after this cycle's broadcast
// -----------------------------------------------------------------------------
module int_issue_queue_iq_wakeup
    import int_issue_queue_pkg::*;
#(
    parameter int TAG_W = IQ_TAG_W
)
(
    input  cdb_bfm            cdb_i,
    input  logic              ready_i,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic [XLEN-1:0]   data_i,
    output logic              ready_o,
    output logic [XLEN-1:0]   data_o
);

    logic hit;

    // Branch resolutions travel on the CDB too but carry no register result.
    assign hit     = ~ready_i & cdb_i.cdb_valid & ~cdb_i.cdb_branch
                   & (cdb_i.cdb_tag == tag_i);
    assign ready_o = ready_i | hit;
    assign data_o  = hit ? cdb_i.cdb_result : data_i;

endmodule : int_issue_queue_iq_wakeup

// File: rtl/int_issue_queue.sv
// -----------------------------------------------------------------------------
// int_issue_queue
// In-order-allocated, out-of-order-issue reservation queue for integer and
// branch ops. Entry 0 is the oldest; entries compact downward on removal so
// the lowest ready index is always the oldest ready op.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   flush_i               - synchronous clear of all entries
//   dispatch_en_i         - write dispatch_data_i this cycle
//   dispatch_data_i       - new op with operand tags and ready flags
//   queue_full_o          - every slot occupied
//   cdb_i                 - CDB broadcast for operand wakeup
//   issue_ready_o         - some valid entry has both operands ready
//   int_exec_fifo_data_o  - payload of the oldest ready entry (0 if none)
//   issue_granted_i       - exec unit consumes int_exec_fifo_data_o
// -----------------------------------------------------------------------------
module int_issue_queue
    import int_issue_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = IQ_TAG_W
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              dispatch_en_i,
    input  int_dispatch_data  dispatch_data_i,
    output logic              queue_full_o,
    input  cdb_bfm            cdb_i,
    output logic              issue_ready_o,
    output int_fifo_data      int_exec_fifo_data_o,
    input  logic              issue_granted_i
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    int_dispatch_data entry_q   [DEPTH];
    int_dispatch_data entry_d   [DEPTH];
    int_dispatch_data woken     [DEPTH];
    int_dispatch_data shift_src [DEPTH];
    int_dispatch_data disp_woken;

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] disp_slot;
    logic [IDX_W-1:0] sel_idx;
    logic             issue_ready;
    logic             do_grant;
    logic             do_disp;
    logic             ready_vec [DEPTH];

    logic             w_rs1_rdy [DEPTH];
    logic             w_rs2_rdy [DEPTH];
    logic [XLEN-1:0]  w_rs1_dat [DEPTH];
    logic [XLEN-1:0]  w_rs2_dat [DEPTH];
    logic             d_rs1_rdy, d_rs2_rdy;
    logic [XLEN-1:0]  d_rs1_dat, d_rs2_dat;

    // ------------------------------------------------------------------
    // Operand wakeup: two per stored entry plus two for the dispatch port,
    // so a broadcast coinciding with dispatch lands in the new slot.
    // ------------------------------------------------------------------
    for (genvar e = 0; e < DEPTH; e++) begin : g_entry_wake
        int_issue_queue_iq_wakeup #(.TAG_W(TAG_W)) u_rs1 (
            .cdb_i   (cdb_i),
            .ready_i (entry_q[e].rs1_ready),
            .tag_i   (entry_q[e].rs1_tag),
            .data_i  (entry_q[e].payload.rs1_data),
            .ready_o (w_rs1_rdy[e]),
            .data_o  (w_rs1_dat[e])
        );
        int_issue_queue_iq_wakeup #(.TAG_W(TAG_W)) u_rs2 (
            .cdb_i   (cdb_i),
            .ready_i (entry_q[e].rs2_ready),
            .tag_i   (entry_q[e].rs2_tag),
            .data_i  (entry_q[e].payload.rs2_data),
            .ready_o (w_rs2_rdy[e]),
            .data_o  (w_rs2_dat[e])
        );

        // Source for slot e when an entry at or below it is removed.
        if (e < DEPTH - 1) begin : g_shift
            assign shift_src[e] = woken[e+1];
        end else begin : g_top
            assign shift_src[e] = woken[e];
        end
    end

    int_issue_queue_iq_wakeup #(.TAG_W(TAG_W)) u_disp_rs1 (
        .cdb_i   (cdb_i),
        .ready_i (dispatch_data_i.rs1_ready),
        .tag_i   (dispatch_data_i.rs1_tag),
        .data_i  (dispatch_data_i.payload.rs1_data),
        .ready_o (d_rs1_rdy),
        .data_o  (d_rs1_dat)
    );
    int_issue_queue_iq_wakeup #(.TAG_W(TAG_W)) u_disp_rs2 (
        .cdb_i   (cdb_i),
        .ready_i (dispatch_data_i.rs2_ready),
        .tag_i   (dispatch_data_i.rs2_tag),
        .data_i  (dispatch_data_i.payload.rs2_data),
        .ready_o (d_rs2_rdy),
        .data_o  (d_rs2_dat)
    );

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woken[i]                  = entry_q[i];
            woken[i].rs1_ready        = w_rs1_rdy[i];
            woken[i].rs2_ready        = w_rs2_rdy[i];
            woken[i].payload.rs1_data = w_rs1_dat[i];
            woken[i].payload.rs2_data = w_rs2_dat[i];
        end
        disp_woken                  = dispatch_data_i;
        disp_woken.rs1_ready        = d_rs1_rdy;
        disp_woken.rs2_ready        = d_rs2_rdy;
        disp_woken.payload.rs1_data = d_rs1_dat;
        disp_woken.payload.rs2_data = d_rs2_dat;
    end

    // ------------------------------------------------------------------
    // Select: looks only at registered state, so an operand woken this
    // cycle becomes eligible on the next one.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch;
        // a path that leaves one unassigned would infer a latch.
        issue_ready = 1'b0;
        sel_idx     = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            ready_vec[i] = (CNT_W'(i) < count_q) && both_ready(entry_q[i]);
            if (ready_vec[i]) begin
                issue_ready = 1'b1;
                sel_idx     = IDX_W'(i);
            end
        end
    end

    assign queue_full_o         = (count_q == CNT_W'(DEPTH));
    assign issue_ready_o        = issue_ready;
    assign int_exec_fifo_data_o = issue_ready ? entry_q[sel_idx].payload : '0;

    // ------------------------------------------------------------------
    // Next state: remove the granted entry by shifting everything above it
    // down one slot, then append the dispatched op at the new tail. A full
    // queue refuses dispatch even when a grant frees a slot that cycle.
    // ------------------------------------------------------------------
    assign do_grant  = issue_granted_i & issue_ready;
    assign do_disp   = dispatch_en_i & ~queue_full_o;
    assign disp_slot = count_q - CNT_W'(do_grant);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_d[i] = (do_grant && (IDX_W'(i) >= sel_idx)) ? shift_src[i] : woken[i];
            if (do_disp && (disp_slot == CNT_W'(i))) begin
                entry_d[i] = disp_woken;
            end
        end
        count_d = count_q - CNT_W'(do_grant) + CNT_W'(do_disp);
        if (flush_i) begin
            count_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // NOTE: entry storage carries no reset; slots at or above count_q are
    // invalid and never reach an output, so only count_q must be cleared.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_q[i] <= entry_d[i];
        end
    end

    count_le_depth: assert property (@(posedge clk) disable iff (!rst_n)
                                     count_q <= CNT_W'(DEPTH));

endmodule : int_issue_queue

// File: tb/tb_int_issue_queue.sv
// -----------------------------------------------------------------------------
// tb_int_issue_queue
// Directed scenarios followed by randomized traffic, all compared against an
// age-ordered queue model of the reservation queue.
// -----------------------------------------------------------------------------
module tb_int_issue_queue;
    import int_issue_queue_pkg::*;

    localparam int DEPTH = 4;

    logic             clk;
    logic             rst_n;
    logic             flush_i;
    logic             dispatch_en_i;
    int_dispatch_data dispatch_data_i;
    logic             queue_full_o;
    cdb_bfm           cdb_i;
    logic             issue_ready_o;
    int_fifo_data     int_exec_fifo_data_o;
    logic             issue_granted_i;

    int n_checks = 0;
    int n_pass   = 0;

    int_dispatch_data mq[$];

    int_issue_queue #(.DEPTH(DEPTH), .TAG_W(IQ_TAG_W)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .flush_i              (flush_i),
        .dispatch_en_i        (dispatch_en_i),
        .dispatch_data_i      (dispatch_data_i),
        .queue_full_o         (queue_full_o),
        .cdb_i                (cdb_i),
        .issue_ready_o        (issue_ready_o),
        .int_exec_fifo_data_o (int_exec_fifo_data_o),
        .issue_granted_i      (issue_granted_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic int model_sel();
        foreach (mq[k]) if (mq[k].rs1_ready && mq[k].rs2_ready) return k;
        return -1;
    endfunction

    function automatic int_fifo_data model_payload();
        int s = model_sel();
        return (s >= 0) ? mq[s].payload : '0;
    endfunction

    function automatic int_dispatch_data wake(input int_dispatch_data e, input cdb_bfm c);
        int_dispatch_data r = e;
        if (c.cdb_valid && !c.cdb_branch) begin
            if (!r.rs1_ready && r.rs1_tag == c.cdb_tag) begin
                r.rs1_ready = 1'b1; r.payload.rs1_data = c.cdb_result;
            end
            if (!r.rs2_ready && r.rs2_tag == c.cdb_tag) begin
                r.rs2_ready = 1'b1; r.payload.rs2_data = c.cdb_result;
            end
        end
        return r;
    endfunction

    function automatic int_dispatch_data mk_op(input logic [IQ_TAG_W-1:0] rd,
            input logic [XLEN-1:0] a, input logic ra, input logic [IQ_TAG_W-1:0] ta,
            input logic [XLEN-1:0] b, input logic rb, input logic [IQ_TAG_W-1:0] tb);
        int_dispatch_data d;
        d.payload.opcode   = OP_ADD;
        d.payload.rd_tag   = rd;
        d.payload.rs1_data = a;
        d.payload.rs2_data = b;
        d.payload.wb_valid = 1'b1;
        d.rs1_tag = ta; d.rs1_ready = ra;
        d.rs2_tag = tb; d.rs2_ready = rb;
        return d;
    endfunction

    function automatic cdb_bfm mk_cdb(input logic v, input logic [IQ_TAG_W-1:0] t,
                                      input logic [XLEN-1:0] r, input logic br);
        cdb_bfm c;
        c.cdb_valid = v; c.cdb_tag = t; c.cdb_result = r; c.cdb_branch = br;
        return c;
    endfunction

    // ---------------- stimulus plumbing ----------------
    task automatic drive(input logic de, input int_dispatch_data dd, input logic gr,
                         input logic fl, input cdb_bfm cc);
        dispatch_en_i   = de;
        dispatch_data_i = dd;
        issue_granted_i = gr;
        flush_i         = fl;
        cdb_i           = cc;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    // One clock edge; the model advances with the inputs held across it.
    task automatic tick();
        logic fl, de, gr;
        int_dispatch_data dd;
        cdb_bfm cc;
        int  sel;
        bit  full;
        fl = flush_i; de = dispatch_en_i; gr = issue_granted_i;
        dd = dispatch_data_i; cc = cdb_i;
        sel  = model_sel();
        full = (mq.size() == DEPTH);
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            if (gr && sel >= 0) mq.delete(sel);
            foreach (mq[k]) mq[k] = wake(mq[k], cc);
            if (de && !full) mq.push_back(wake(dd, cc));
        end
        #1;
    endtask

    task automatic dispatch_one(input int_dispatch_data d);
        drive(1'b1, d, 1'b0, 1'b0, '0);
        tick();
        idle();
    endtask

    task automatic grant_one();
        drive(1'b0, '0, 1'b1, 1'b0, '0);
        tick();
        idle();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        #12;
        n_checks++; if (issue_ready_o !== 1'b0) $display("FAIL reset_issue_ready got=%b exp=0", issue_ready_o); else n_pass++;
        n_checks++; if (queue_full_o !== 1'b0) $display("FAIL reset_queue_full got=%b exp=0", queue_full_o); else n_pass++;
        n_checks++; if (int_exec_fifo_data_o !== '0) $display("FAIL reset_payload got=%h exp=0", int_exec_fifo_data_o); else n_pass++;
        rst_n = 1'b1;
        tick();
        n_checks++; if (issue_ready_o !== 1'b0) $display("FAIL reset_after_release got=%b exp=0", issue_ready_o); else n_pass++;
    endtask

    task automatic test_basic_issue();
        int_dispatch_data d;
        d = mk_op(7, 5, 1'b1, 1, 3, 1'b1, 2);
        d.payload.wb_valid = 1'b0;
        dispatch_one(d);
        n_checks++; if (issue_ready_o !== 1'b1) $display("FAIL basic_ready got=%b exp=1", issue_ready_o); else n_pass++;
        n_checks++; if (int_exec_fifo_data_o.rs1_data !== 32'd5) $display("FAIL basic_rs1 got=%0d exp=5", int_exec_fifo_data_o.rs1_data); else n_pass++;
        n_checks++; if (int_exec_fifo_data_o.rs2_data !== 32'd3) $display("FAIL basic_rs2 got=%0d exp=3", int_exec_fifo_data_o.rs2_data); else n_pass++;
        n_checks++; if (int_exec_fifo_data_o.rd_tag !== 6'd7) $display("FAIL basic_rd got=%0d exp=7", int_exec_fifo_data_o.rd_tag); else n_pass++;
        n_checks++; if (int_exec_fifo_data_o.opcode !== OP_ADD || int_exec_fifo_data_o.wb_valid !== 1'b0)
            $display("FAIL basic_op_wb got=%0d/%b exp=0/0", int_exec_fifo_data_o.opcode, int_exec_fifo_data_o.wb_valid); else n_pass++;
        grant_one();
        n_checks++; if (issue_ready_o !== 1'b0) $display("FAIL basic_empty got=%b exp=0", issue_ready_o); else n_pass++;
    endtask

    task automatic test_ooo_wakeup();
        dispatch_one(mk_op(11, 0, 1'b0, 9, 2, 1'b1, 0));
        dispatch_one(mk_op(12, 1, 1'b1, 0, 1, 1'b1, 0));
        n_checks++; if (issue_ready_o !== 1'b1 || int_exec_fifo_data_o.rd_tag !== 6'd12)
            $display("FAIL ooo_younger_first got=%b/%0d exp=1/12", issue_ready_o, int_exec_fifo_data_o.rd_tag); else n_pass++;
        grant_one();
        n_checks++; if (issue_ready_o !== 1'b0) $display("FAIL ooo_waiting got=%b exp=0", issue_ready_o); else n_pass++;
        drive(1'b0, '0, 1'b0, 1'b0, mk_cdb(1'b1, 9, 32'h10, 1'b0));
        #1;
        n_checks++; if (issue_ready_o !== 1'b0) $display("FAIL ooo_same_cycle got=%b exp=0", issue_ready_o); else n_pass++;
        tick();
        idle();
        n_checks++; if (issue_ready_o !== 1'b1 || int_exec_fifo_data_o.rd_tag !== 6'd11)
            $display("FAIL ooo_woken got=%b/%0d exp=1/11", issue_ready_o, int_exec_fifo_data_o.rd_tag); else n_pass++;
        n_checks++; if (int_exec_fifo_data_o.rs1_data !== 32'h10) $display("FAIL ooo_rs1_data got=%h exp=10", int_exec_fifo_data_o.rs1_data); else n_pass++;
        grant_one();
        n_checks++; if (issue_ready_o !== 1'b0) $display("FAIL ooo_drained got=%b exp=0", issue_ready_o); else n_pass++;
    endtask

    task automatic test_full();
        for (int k = 1; k <= 4; k++) dispatch_one(mk_op(6'(k), 32'(k), 1'b1, 0, 0, 1'b1, 0));
        n_checks++; if (queue_full_o !== 1'b1) $display("FAIL full_set got=%b exp=1", queue_full_o); else n_pass++;
        dispatch_one(mk_op(5, 0, 1'b1, 0, 0, 1'b1, 0));
        n_checks++; if (queue_full_o !== 1'b1 || int_exec_fifo_data_o.rd_tag !== 6'd1)
            $display("FAIL full_drop got=%b/%0d exp=1/1", queue_full_o, int_exec_fifo_data_o.rd_tag); else n_pass++;
        // Grant and dispatch together on a full queue: the dispatch is refused.
        drive(1'b1, mk_op(6, 0, 1'b1, 0, 0, 1'b1, 0), 1'b1, 1'b0, '0);
        tick();
        idle();
        n_checks++; if (queue_full_o !== 1'b0 || int_exec_fifo_data_o.rd_tag !== 6'd2)
            $display("FAIL full_grant got=%b/%0d exp=0/2", queue_full_o, int_exec_fifo_data_o.rd_tag); else n_pass++;
        for (int k = 3; k <= 4; k++) begin
            grant_one();
            n_checks++; if (int_exec_fifo_data_o.rd_tag !== 6'(k)) $display("FAIL full_order got=%0d exp=%0d", int_exec_fifo_data_o.rd_tag, k); else n_pass++;
        end
        grant_one();
        n_checks++; if (issue_ready_o !== 1'b0) $display("FAIL full_no_extra got=%b exp=0", issue_ready_o); else n_pass++;
    endtask

    task automatic test_bypass_branch();
        drive(1'b1, mk_op(20, 1, 1'b1, 0, 0, 1'b0, 4), 1'b0, 1'b0, mk_cdb(1'b1, 4, 32'hABCD, 1'b0));
        tick();
        idle();
        n_checks++; if (issue_ready_o !== 1'b1 || int_exec_fifo_data_o.rs2_data !== 32'hABCD)
            $display("FAIL bypass got=%b/%h exp=1/abcd", issue_ready_o, int_exec_fifo_data_o.rs2_data); else n_pass++;
        grant_one();
        drive(1'b1, mk_op(21, 1, 1'b1, 0, 0, 1'b0, 4), 1'b0, 1'b0, mk_cdb(1'b1, 4, 32'h55, 1'b1));
        tick();
        drive(1'b0, '0, 1'b0, 1'b0, mk_cdb(1'b1, 4, 32'h66, 1'b1));
        tick();
        idle();
        n_checks++; if (issue_ready_o !== 1'b0) $display("FAIL branch_no_wake got=%b exp=0", issue_ready_o); else n_pass++;
    endtask

    task automatic test_flush();
        dispatch_one(mk_op(22, 0, 1'b1, 0, 0, 1'b1, 0));
        dispatch_one(mk_op(23, 0, 1'b1, 0, 0, 1'b1, 0));
        n_checks++; if (issue_ready_o !== 1'b1 || int_exec_fifo_data_o.rd_tag !== 6'd22)
            $display("FAIL flush_pre got=%b/%0d exp=1/22", issue_ready_o, int_exec_fifo_data_o.rd_tag); else n_pass++;
        drive(1'b1, mk_op(24, 0, 1'b1, 0, 0, 1'b1, 0), 1'b1, 1'b1, '0);
        tick();
        idle();
        n_checks++; if (issue_ready_o !== 1'b0 || queue_full_o !== 1'b0)
            $display("FAIL flush_clear got=%b/%b exp=0/0", issue_ready_o, queue_full_o); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            dispatch_one(mk_op(6'(30 + k), 0, 1'b1, 0, 0, 1'b1, 0));
            n_checks++; if (queue_full_o !== (k == 3)) $display("FAIL flush_count k=%0d got=%b exp=%b", k, queue_full_o, k == 3); else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        n_checks++; if (queue_full_o !== 1'b1) $display("FAIL areset_pre got=%b exp=1", queue_full_o); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        mq.delete();
        n_checks++; if (queue_full_o !== 1'b0 || issue_ready_o !== 1'b0 || int_exec_fifo_data_o !== '0)
            $display("FAIL areset_immediate got=%b/%b/%h exp=0/0/0", queue_full_o, issue_ready_o, int_exec_fifo_data_o); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_checks++; if (issue_ready_o !== 1'b0) $display("FAIL areset_after got=%b exp=0", issue_ready_o); else n_pass++;
    endtask

    task automatic test_random();
        int_dispatch_data d;
        int_fifo_data     exp_pl;
        logic             exp_rdy, exp_full;
        for (int n = 0; n < 400; n++) begin
            d.payload.opcode   = opcode_e'($urandom_range(0, 7));
            d.payload.rd_tag   = 6'($urandom_range(0, 63));
            d.payload.rs1_data = $urandom;
            d.payload.rs2_data = $urandom;
            d.payload.wb_valid = 1'($urandom_range(0, 1));
            d.rs1_tag   = 6'($urandom_range(0, 7));
            d.rs2_tag   = 6'($urandom_range(0, 7));
            d.rs1_ready = ($urandom_range(0, 2) != 0);
            d.rs2_ready = ($urandom_range(0, 2) != 0);
            drive(($urandom_range(0, 2) != 0), d, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 39) == 0),
                  mk_cdb(1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), $urandom,
                         ($urandom_range(0, 3) == 0)));
            tick();
            exp_rdy  = (model_sel() >= 0);
            exp_pl   = model_payload();
            exp_full = (mq.size() == DEPTH);
            n_checks++; if (issue_ready_o !== exp_rdy) $display("FAIL rand_ready n=%0d got=%b exp=%b", n, issue_ready_o, exp_rdy); else n_pass++;
            n_checks++; if (int_exec_fifo_data_o !== exp_pl) $display("FAIL rand_payload n=%0d got=%h exp=%h", n, int_exec_fifo_data_o, exp_pl); else n_pass++;
            n_checks++; if (queue_full_o !== exp_full) $display("FAIL rand_full n=%0d got=%b exp=%b", n, queue_full_o, exp_full); else n_pass++;
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_basic_issue();
        test_ooo_wakeup();
        test_full();
        test_bypass_branch();
        test_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_int_issue_queue
